// File: rtl/inval_arb_pkg.sv
// Shared definitions for the L1 invalidation path: line-offset width and line address type.
package inval_arb_pkg;

  localparam int unsigned DefAddrWidth   = 64;
  localparam int unsigned DefL1LineWidth = 16;
  localparam int unsigned LineOffW       = $clog2(DefL1LineWidth);
  localparam int unsigned LineAddrW      = DefAddrWidth - LineOffW;

  typedef logic [LineAddrW-1:0] line_addr_t;

  function automatic line_addr_t line_of(input logic [DefAddrWidth-1:0] addr);
    return addr[DefAddrWidth-1:LineOffW];
  endfunction

endpackage

// File: rtl/inval_hist_cam.sv
// Small FIFO-replacement CAM of recently issued invalidation lines.
module inval_hist_cam #(
  parameter int unsigned Depth = 4,
  parameter int unsigned LineW = 60
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic [LineW-1:0] wline_i,
  input  logic [LineW-1:0] lookup_i,
  output logic             hit_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [LineW-1:0] line_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  wptr_q;

  // Clear is applied before the write so an entry written alongside a refill survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      wptr_q  <= '0;
    end else begin
      if (clear_i) valid_q <= '0;
      if (write_i) begin
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_i) line_q[wptr_q] <= wline_i;
  end

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i] && (line_q[i] == lookup_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/inval_req_arbiter.sv
// Round-robin arbiter sharing the L1 invalidation port, with redundant-line suppression.
module inval_req_arbiter
  import inval_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned AddrWidth   = DefAddrWidth,
  parameter int unsigned L1LineWidth = DefL1LineWidth,
  parameter int unsigned HistDepth   = 4,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        refill_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic [AddrWidth-1:0]        inval_addr_o,
  output logic                        inval_valid_o,
  input  logic                        inval_ready_i,
  output logic [CntWidth-1:0]         issued_cnt_o,
  output logic [CntWidth-1:0]         dropped_cnt_o,
  output logic                        idle_o
);

  localparam int unsigned OffW  = $clog2(L1LineWidth);
  localparam int unsigned LineW = AddrWidth - OffW;
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [LineW-1:0]    req_line [NumReq];
  logic [IdxW-1:0]     rr_q;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_found;
  int unsigned         scan_idx;
  logic [LineW-1:0]    gnt_line;
  logic [LineW-1:0]    out_line_q;
  logic                out_valid_q;
  logic                hist_hit;
  logic                out_hit;
  logic                hit;
  logic                hs;
  logic                miss_hs;
  logic [CntWidth-1:0] issued_q;
  logic [CntWidth-1:0] dropped_q;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_line[i] = req_addr_i[i*AddrWidth + OffW +: LineW];
    end
  end

  // First valid requester at or above the RR pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      scan_idx = int'(unsigned'(rr_q)) + k;
      if (scan_idx >= NumReq) scan_idx = scan_idx - NumReq;
      if (!gnt_found && req_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(scan_idx);
      end
    end
  end

  assign gnt_line = req_line[gnt_idx];

  inval_hist_cam #(
    .Depth(HistDepth),
    .LineW(LineW)
  ) u_hist (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (refill_i),
    .write_i (miss_hs & en_i),
    .wline_i (gnt_line),
    .lookup_i(gnt_line),
    .hit_o   (hist_hit)
  );

  // Hits are always accepted; misses wait for room in the output stage.
  always_comb begin
    out_hit     = out_valid_q && (out_line_q == gnt_line);
    hit         = en_i & gnt_found & (hist_hit | out_hit);
    hs          = gnt_found & ~rst_i & (hit | ~out_valid_q | inval_ready_i);
    miss_hs     = hs & ~hit;
    req_ready_o = hs ? (NumReq'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_line_q  <= '0;
      issued_q    <= '0;
      dropped_q   <= '0;
    end else begin
      if (hs) rr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
      if (miss_hs) begin
        out_valid_q <= 1'b1;
        out_line_q  <= gnt_line;
      end else if (inval_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && inval_ready_i) issued_q <= issued_q + CntWidth'(1);
      if (hs && hit) dropped_q <= dropped_q + CntWidth'(1);
    end
  end

  assign inval_addr_o  = {out_line_q, OffW'(0)};
  assign inval_valid_o = out_valid_q;
  assign issued_cnt_o  = issued_q;
  assign dropped_cnt_o = dropped_q;
  assign idle_o        = ~|req_valid_i & ~out_valid_q;

endmodule

// File: tb/tb_inval_req_arbiter.sv
// Directed self-checking bench for inval_req_arbiter with default parameters.
module tb_inval_req_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         refill_i;
  logic [255:0] req_addr_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [63:0]  inval_addr_o;
  logic         inval_valid_o;
  logic         inval_ready_i;
  logic [31:0]  issued_cnt_o;
  logic [31:0]  dropped_cnt_o;
  logic         idle_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  inval_req_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .refill_i     (refill_i),
    .req_addr_i   (req_addr_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .inval_addr_o (inval_addr_o),
    .inval_valid_o(inval_valid_o),
    .inval_ready_i(inval_ready_i),
    .issued_cnt_o (issued_cnt_o),
    .dropped_cnt_o(dropped_cnt_o),
    .idle_o       (idle_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; refill_i = 1'b0;
    req_addr_i = '0; req_valid_i = '0; inval_ready_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({inval_valid_o, issued_cnt_o, dropped_cnt_o} !== 65'd0)
      $display("FAIL reset_regs: valid=%0b issued=%0d dropped=%0d want 0", inval_valid_o, issued_cnt_o, dropped_cnt_o);
    else n_pass++;
    n_total++;
    if ({idle_o, req_ready_o} !== 5'b1_0000)
      $display("FAIL reset_idle: idle=%0b ready=%b want idle=1 ready=0000", idle_o, req_ready_o);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req_addr_i[63:0] = 64'h1008; req_valid_i = 4'b0001; #1;
    n_total++;
    if (req_ready_o !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    n_total++;
    if (inval_valid_o !== 1'b1 || inval_addr_o !== 64'h1000)
      $display("FAIL single_out: valid=%0b addr=%h want 1/1000", inval_valid_o, inval_addr_o);
    else n_pass++;
    tick();
    n_total++;
    if (issued_cnt_o !== 32'd1 || inval_valid_o !== 1'b0 || idle_o !== 1'b1)
      $display("FAIL single_issued: issued=%0d valid=%0b idle=%0b want 1/0/1", issued_cnt_o, inval_valid_o, idle_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    en_i = 1'b0;
    for (int k = 0; k < 4; k++) req_addr_i[k*64 +: 64] = 64'(k * 16);
    req_valid_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = 4'b0001 << k;
      n_total++;
      if (req_ready_o !== exp_rdy) $display("FAIL rr_grant%0d: got %b want %b", k, req_ready_o, exp_rdy); else n_pass++;
      tick();
      req_valid_i[k] = 1'b0;
      n_total++;
      if (inval_valid_o !== 1'b1 || inval_addr_o !== 64'(k * 16))
        $display("FAIL rr_out%0d: valid=%0b addr=%h want 1/%h", k, inval_valid_o, inval_addr_o, 64'(k * 16));
      else n_pass++;
    end
    req_valid_i = 4'b1001; #1;
    n_total++;
    if (req_ready_o !== 4'b0001) $display("FAIL rr_wrap: got %b want 0001", req_ready_o); else n_pass++;
    req_valid_i = '0;
    tick();
    n_total++;
    if (issued_cnt_o !== 32'd4 || dropped_cnt_o !== 32'd0)
      $display("FAIL rr_counts: issued=%0d dropped=%0d want 4/0", issued_cnt_o, dropped_cnt_o);
    else n_pass++;
  endtask

  task automatic test_hit_drop();
    do_reset();
    en_i = 1'b1;
    req_addr_i[63:0] = 64'h40; req_valid_i = 4'b0001;
    tick();
    req_valid_i = 4'b0000;
    req_addr_i[127:64] = 64'h44; req_valid_i = 4'b0010; #1;
    n_total++;
    if (req_ready_o !== 4'b0010) $display("FAIL hit_ready: got %b want 0010", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    n_total++;
    if (dropped_cnt_o !== 32'd1 || issued_cnt_o !== 32'd1 || inval_valid_o !== 1'b0)
      $display("FAIL hit_drop: dropped=%0d issued=%0d valid=%0b want 1/1/0", dropped_cnt_o, issued_cnt_o, inval_valid_o);
    else n_pass++;
  endtask

  task automatic test_refill();
    do_reset();
    en_i = 1'b1;
    req_addr_i[63:0] = 64'h40; req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    tick();
    refill_i = 1'b1;
    tick();
    refill_i = 1'b0;
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    n_total++;
    if (inval_valid_o !== 1'b1 || inval_addr_o !== 64'h40 || dropped_cnt_o !== 32'd0)
      $display("FAIL refill_fwd: valid=%0b addr=%h dropped=%0d want 1/40/0", inval_valid_o, inval_addr_o, dropped_cnt_o);
    else n_pass++;
    tick();
    n_total++;
    if (issued_cnt_o !== 32'd2) $display("FAIL refill_issued: got %0d want 2", issued_cnt_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    en_i = 1'b1; inval_ready_i = 1'b0;
    req_addr_i[63:0] = 64'h100; req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    req_addr_i[191:128] = 64'h200; req_valid_i = 4'b0100; #1;
    n_total++;
    if (req_ready_o !== 4'b0000) $display("FAIL bp_stall: got %b want 0000", req_ready_o); else n_pass++;
    tick(); tick();
    n_total++;
    if (inval_valid_o !== 1'b1 || inval_addr_o !== 64'h100 || issued_cnt_o !== 32'd0)
      $display("FAIL bp_stable: valid=%0b addr=%h issued=%0d want 1/100/0", inval_valid_o, inval_addr_o, issued_cnt_o);
    else n_pass++;
    inval_ready_i = 1'b1; #1;
    n_total++;
    if (req_ready_o !== 4'b0100) $display("FAIL bp_release: got %b want 0100", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    n_total++;
    if (inval_addr_o !== 64'h200 || inval_valid_o !== 1'b1 || issued_cnt_o !== 32'd1)
      $display("FAIL bp_reload: addr=%h valid=%0b issued=%0d want 200/1/1", inval_addr_o, inval_valid_o, issued_cnt_o);
    else n_pass++;
    tick();
    n_total++;
    if (issued_cnt_o !== 32'd2) $display("FAIL bp_issued: got %0d want 2", issued_cnt_o); else n_pass++;
  endtask

  task automatic test_eviction();
    logic [63:0] lines [6];
    lines = '{64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h5000, 64'h1000};
    do_reset();
    en_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      req_addr_i[63:0] = lines[k];
      tick();
      n_total++;
      if (inval_addr_o !== lines[k] || inval_valid_o !== 1'b1 || dropped_cnt_o !== 32'd0)
        $display("FAIL evict_fwd%0d: addr=%h valid=%0b dropped=%0d want %h/1/0", k, inval_addr_o, inval_valid_o, dropped_cnt_o, lines[k]);
      else n_pass++;
    end
    req_addr_i[63:0] = 64'h4008; #1;
    n_total++;
    if (req_ready_o !== 4'b0001) $display("FAIL evict_hit_ready: got %b want 0001", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    n_total++;
    if (dropped_cnt_o !== 32'd1 || issued_cnt_o !== 32'd6 || inval_valid_o !== 1'b0)
      $display("FAIL evict_drop: dropped=%0d issued=%0d valid=%0b want 1/6/0", dropped_cnt_o, issued_cnt_o, inval_valid_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hit_drop();
    test_refill();
    test_backpressure();
    test_eviction();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
